mux3_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer for a shared 3:1, 32-bit word mux (the `mux3_1` selector used on CGRA operand/result paths). Three requesters present words on the mux inputs `in_1`..`in_3` with valid/ready handshakes. This block picks one requester per transfer and drives the mux `sel`. It captures the mux `data_out` into a registered output stage with a valid/ready handshake toward the consumer. It sits between the requester tiles and the shared downstream consumer; the mux itself stays external.

---
 rtl/mux3_rr_arbiter.sv | 76 +++++++
 tb/tb_mux3_rr_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux3_rr_arbiter.sv
// Round-robin arbiter/sequencer for an external 3:1 word mux, with a
// registered valid/ready output stage capturing the selected mux word.
module mux3_rr_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       req_valid,
  output logic [2:0]       req_ready,
  output logic [1:0]       mux_sel,
  input  logic [WIDTH-1:0] mux_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_src
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t     state, state_nxt;
  logic [1:0] last;
  logic [1:0] win;
  logic [1:0] cand;
  logic       grant;
  logic       can_load;
  logic       load;

  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  always_comb begin
    win       = last;
    grant     = 1'b0;
    cand      = last;
    state_nxt = state;
    req_ready = '0;
    mux_sel   = last;
    // Visit last+1, last+2, last in turn; the first requester seen wins.
    for (int unsigned i = 0; i < 3; i++) begin
      cand = inc3(cand);
      if (!grant && req_valid[cand]) begin
        grant = 1'b1;
        win   = cand;
      end
    end
    can_load = (state == EMPTY) || out_ready;
    load     = can_load && grant && rst_n;
    if (load) begin
      req_ready = 3'b001 << win;
      mux_sel   = win;
      state_nxt = FULL;
    end else if (can_load) begin
      state_nxt = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      last     <= 2'd2;
      out_data <= '0;
      out_src  <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        last     <= win;
        out_data <= mux_data;
        out_src  <= win;
      end
    end
  end

  assign out_valid = (state == FULL);

endmodule

// File: tb/tb_mux3_rr_arbiter.sv
// Self-checking bench for mux3_rr_arbiter: vector table, directed corner
// sequences, and randomized traffic against a round-robin reference model.
module tb_mux3_rr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [1:0]  mux_sel;
  logic [31:0] mux_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_src;
  logic [31:0] in_1, in_2, in_3;

  int errors = 0;
  int checks = 0;

  mux3_rr_arbiter #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .mux_sel   (mux_sel),
    .mux_data  (mux_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src)
  );

  // External mux model
  always_comb begin
    case (mux_sel)
      2'd0:    mux_data = in_1;
      2'd1:    mux_data = in_2;
      2'd2:    mux_data = in_3;
      default: mux_data = '0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] rv;
    logic       ordy;
    logic [2:0] rr;
    logic [1:0] sel;
    logic       ov;
    logic [1:0] src;
  } vec_t;

  vec_t        tbl [15];
  logic [31:0] words [3];

  // Reference model state
  logic        m_valid;
  logic [31:0] m_data;
  int          m_src;
  int          m_last;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic invariants();
    chk("sel_not_3", {31'd0, mux_sel != 2'b11}, 32'd1);
    chk("ready_onehot0", {31'd0, $onehot0(req_ready)}, 32'd1);
  endtask

  task automatic apply(input logic [2:0] rv, input logic ordy);
    req_valid = rv;
    out_ready = ordy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    out_ready = 1'b0;
    m_valid   = 1'b0;
    m_data    = '0;
    m_src     = 0;
    m_last    = 2;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] in_word(input int k);
    return (k == 0) ? in_1 : (k == 1) ? in_2 : in_3;
  endfunction

  initial begin
    in_1 = 32'hA5A5A5A5; in_2 = 32'h5A5A5A5A; in_3 = 32'h12345678;
    words[0] = in_1; words[1] = in_2; words[2] = in_3;
    tbl[0]  = '{3'b111, 1'b1, 3'b001, 2'd0, 1'b1, 2'd0};
    tbl[1]  = '{3'b111, 1'b1, 3'b010, 2'd1, 1'b1, 2'd1};
    tbl[2]  = '{3'b111, 1'b1, 3'b100, 2'd2, 1'b1, 2'd2};
    tbl[3]  = '{3'b111, 1'b1, 3'b001, 2'd0, 1'b1, 2'd0};
    tbl[4]  = '{3'b111, 1'b1, 3'b010, 2'd1, 1'b1, 2'd1};
    tbl[5]  = '{3'b111, 1'b1, 3'b100, 2'd2, 1'b1, 2'd2};
    tbl[6]  = '{3'b000, 1'b1, 3'b000, 2'd2, 1'b0, 2'd2};
    tbl[7]  = '{3'b000, 1'b1, 3'b000, 2'd2, 1'b0, 2'd2};
    tbl[8]  = '{3'b100, 1'b0, 3'b100, 2'd2, 1'b1, 2'd2};
    tbl[9]  = '{3'b011, 1'b0, 3'b000, 2'd2, 1'b1, 2'd2};
    tbl[10] = '{3'b011, 1'b0, 3'b000, 2'd2, 1'b1, 2'd2};
    tbl[11] = '{3'b011, 1'b1, 3'b001, 2'd0, 1'b1, 2'd0};
    tbl[12] = '{3'b001, 1'b1, 3'b001, 2'd0, 1'b1, 2'd0};
    tbl[13] = '{3'b001, 1'b1, 3'b001, 2'd0, 1'b1, 2'd0};
    tbl[14] = '{3'b000, 1'b1, 3'b000, 2'd0, 1'b0, 2'd0};

    // Reset state
    do_reset();
    apply(3'b000, 1'b0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_src", {30'd0, out_src}, 32'd0);
    chk("rst_mux_sel", {30'd0, mux_sel}, 32'd2);
    chk("rst_req_ready", {29'd0, req_ready}, 32'd0);

    // Table: rotation, drain, idle out_ready, backpressure, persistent requester
    for (int i = 0; i < 15; i++) begin
      apply(tbl[i].rv, tbl[i].ordy);
      chk($sformatf("tbl%0d_req_ready", i), {29'd0, req_ready}, {29'd0, tbl[i].rr});
      chk($sformatf("tbl%0d_mux_sel", i), {30'd0, mux_sel}, {30'd0, tbl[i].sel});
      invariants();
      tick();
      chk($sformatf("tbl%0d_out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].ov});
      chk($sformatf("tbl%0d_out_src", i), {30'd0, out_src}, {30'd0, tbl[i].src});
      chk($sformatf("tbl%0d_out_data", i), out_data, words[tbl[i].src]);
    end

    // Single requester 1 right after reset
    do_reset();
    apply(3'b010, 1'b1);
    chk("single_req_ready", {29'd0, req_ready}, 32'd2);
    chk("single_mux_sel", {30'd0, mux_sel}, 32'd1);
    tick();
    chk("single_out_valid", {31'd0, out_valid}, 32'd1);
    chk("single_out_data", out_data, 32'h5A5A5A5A);
    chk("single_out_src", {30'd0, out_src}, 32'd1);

    // Backpressure holding DEADBEEF from src 2
    in_3 = 32'hDEADBEEF;
    apply(3'b100, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      apply(3'b111, 1'b0);
      chk("bp_req_ready", {29'd0, req_ready}, 32'd0);
      tick();
      chk("bp_out_data", out_data, 32'hDEADBEEF);
      chk("bp_out_src", {30'd0, out_src}, 32'd2);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    end
    apply(3'b111, 1'b1);
    chk("bp_release_ready", {29'd0, req_ready}, 32'd1);
    tick();
    chk("bp_release_data", out_data, 32'hA5A5A5A5);

    // Async reset between edges
    apply(3'b111, 1'b1);
    tick();
    apply(3'b111, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("areset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("areset_req_ready", {29'd0, req_ready}, 32'd0);
    chk("areset_out_data", out_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    in_1 = 32'hFFFFFFFF; in_3 = 32'h00000000;
    apply(3'b101, 1'b1);
    chk("areset_first_ready", {29'd0, req_ready}, 32'd1);
    tick();
    chk("areset_first_data", out_data, 32'hFFFFFFFF);
    chk("areset_first_src", {30'd0, out_src}, 32'd0);

    // Randomized traffic against the reference model
    do_reset();
    begin
      logic [2:0] rv;
      logic       ordy;
      logic       stalled;
      logic       can_load;
      int         w;
      logic [2:0] exp_rr;
      int         exp_sel;
      stalled = 1'b0;
      rv = '0;
      for (int n = 0; n < 400; n++) begin
        if (!stalled) begin
          rv   = 3'($urandom);
          in_1 = $urandom; in_2 = $urandom; in_3 = $urandom;
        end
        ordy = ($urandom_range(0, 3) != 0);
        apply(rv, ordy);
        w = -1;
        for (int off = 1; off <= 3; off++)
          if (w < 0 && rv[(m_last + off) % 3]) w = (m_last + off) % 3;
        can_load = !m_valid || ordy;
        exp_rr   = (can_load && w >= 0) ? 3'(1 << w) : 3'b000;
        exp_sel  = (can_load && w >= 0) ? w : m_last;
        chk("rnd_req_ready", {29'd0, req_ready}, {29'd0, exp_rr});
        chk("rnd_mux_sel", {30'd0, mux_sel}, 32'(exp_sel));
        invariants();
        if (can_load && w >= 0) begin
          m_valid = 1'b1;
          m_data  = in_word(w);
          m_src   = w;
          m_last  = w;
        end else if (can_load) begin
          m_valid = 1'b0;
        end
        stalled = !can_load;
        tick();
        chk("rnd_out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        chk("rnd_out_data", out_data, m_data);
        chk("rnd_out_src", {30'd0, out_src}, 32'(m_src));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
